router_reg_param: RTL and testbench
===================================

ROUTER_REG_PARAM -- requirements
Module: router_reg_param

Interface
REQ-001 Parameter DATA_W, default 8, data byte width in bits (minimum 4).
REQ-002 Parameter ADDR_W, default 2, width of destination field in header bits [ADDR_W-1:0].
REQ-003 Parameter NUM_PORTS, default 3, valid destinations are 0..NUM_PORTS-1 (at most 2^ADDR_W).
REQ-004 Parameter HOLD_DEPTH, default 2, entries in the full-state holding buffer (minimum 1).
REQ-005 Parameter PARITY_MODE, default 0; 0 = bitwise XOR, 1 = modulo-2^DATA_W sum.
REQ-006 Parameter CNT_W, default 8, width of the error counter.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 resetn  in  1  reset, synchronous, active-low.
REQ-009 pkt_valid  in  1  source packet valid; low marks the parity byte.
REQ-010 data_in  in  DATA_W  incoming header/payload/parity byte.
REQ-011 fifo_full  in  1  selected output FIFO full.
REQ-012 detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state decodes, at most one high per cycle.
REQ-013 rst_int_reg  in  1  clears low_pkt_valid.
REQ-014 dout  out  DATA_W  byte to output FIFO.
REQ-015 dout_valid  out  1  dout written this cycle (one-cycle pulse per byte).
REQ-016 hold_cnt  out  clog2(HOLD_DEPTH+1)  occupied holding-buffer entries.
REQ-017 hold_ovf  out  1  sticky: byte arrived while holding buffer full.
REQ-018 addr_err  out  1  one-cycle pulse: header destination >= NUM_PORTS.
REQ-019 low_pkt_valid, parity_done, err  out  1 each  as defined below.
REQ-020 err_count  out  CNT_W  count of packets with parity mismatch.

Function
REQ-021 Header capture: detect_add && pkt_valid && dest < NUM_PORTS SHALL load header register; dest >= NUM_PORTS SHALL leave header unchanged and pulse addr_err next cycle.
REQ-022 detect_add SHALL clear int_parity, ext_parity, parity_done, err, hold_cnt, hold_ovf.
REQ-023 lfd_state: dout <= header, dout_valid=1, int_parity <= header.
REQ-024 ld_state && !fifo_full && hold_cnt==0: dout <= data_in, dout_valid=1.
REQ-025 ld_state && (fifo_full || hold_cnt!=0): data_in pushed into holding buffer (FIFO order), dout unchanged, dout_valid=0.
REQ-026 Push with hold_cnt==HOLD_DEPTH SHALL drop the byte and set hold_ovf; hold_cnt unchanged.
REQ-027 laf_state && hold_cnt!=0 && !fifo_full: oldest entry to dout, dout_valid=1, hold_cnt decrements; laf_state with empty buffer: no write.
REQ-028 Simultaneous push and pop impossible (exclusive states); no other path alters hold_cnt.
REQ-029 Accumulation: each accepted payload byte with pkt_valid=1 in ld_state updates int_parity (XOR or sum per PARITY_MODE, carry discarded); dropped bytes SHALL NOT accumulate.
REQ-030 Parity byte: ld_state && !pkt_valid with byte accepted (written or pushed) SHALL load ext_parity <= data_in, set parity_done and low_pkt_valid same edge; parity byte not accumulated.
REQ-031 parity_done SHALL remain high until detect_add; low_pkt_valid until rst_int_reg.
REQ-032 err SHALL go high one cycle after parity_done rises iff int_parity != ext_parity or hold_ovf, and stay high until detect_add.
REQ-033 err_count SHALL increment once per err rising edge, saturating at 2^CNT_W-1.
REQ-034 full_state alone SHALL alter no register.

Reset
REQ-035 resetn=0 at clk edge SHALL zero dout, header, holding buffer, hold_cnt, int_parity, ext_parity and all 1-bit outputs, and err_count; reset overrides every other input, including mid-packet.

Verification
REQ-036 Header 0x05, payload 0x11,0x22, parity 0x36 (XOR), fifo_full=0 -> dout 0x05,0x11,0x22,0x36 with dout_valid each; parity_done=1, err=0.
REQ-037 Same packet, parity 0x00 -> err=1 one cycle after parity_done; err_count 0->1.
REQ-038 fifo_full high for 2 payload bytes 0xAA,0xBB, HOLD_DEPTH=2 -> hold_cnt=2; laf_state pops 0xAA then 0xBB; hold_ovf=0.
REQ-039 HOLD_DEPTH=1, fifo_full for 2 bytes -> second dropped, hold_ovf=1, err=1 after parity.
REQ-040 Header dest=3 with NUM_PORTS=3 -> addr_err pulse, header unchanged; PARITY_MODE=1, payload 0xFF,0x02, header 0x01 -> int_parity 0x02.
REQ-041 resetn low mid-payload with hold_cnt=1 -> all outputs 0 next edge, err_count 0.

Source files
------------

// File: rtl/router_reg_param.sv
// Router datapath register: captures the header, forwards or holds payload bytes,
// accumulates parity, flags parity/overflow errors and counts errored packets.
module router_reg_param #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int NUM_PORTS   = 3,
    parameter int HOLD_DEPTH  = 2,
    parameter int PARITY_MODE = 0,
    parameter int CNT_W       = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              pkt_valid,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              fifo_full,
    input  logic                              detect_add,
    input  logic                              lfd_state,
    input  logic                              ld_state,
    input  logic                              laf_state,
    input  logic                              full_state,
    input  logic                              rst_int_reg,
    output logic [DATA_W-1:0]                 dout,
    output logic                              dout_valid,
    output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_cnt,
    output logic                              hold_ovf,
    output logic                              addr_err,
    output logic                              low_pkt_valid,
    output logic                              parity_done,
    output logic                              err,
    output logic [CNT_W-1:0]                  err_count
);
    localparam int HC_W = $clog2(HOLD_DEPTH + 1);
    localparam logic [HC_W-1:0] HOLD_FULL = HC_W'(HOLD_DEPTH);

    function automatic logic [DATA_W-1:0] parity_acc(input logic [DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0] b);
        if (PARITY_MODE == 1) return acc + b;
        return acc ^ b;
    endfunction

    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [DATA_W-1:0] hold_mem_q [HOLD_DEPTH];
    logic [DATA_W-1:0] hold_mem_d [HOLD_DEPTH];
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              hold_ovf_q, hold_ovf_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] ext_par_q, ext_par_d;
    logic              pd_q, pd_d;
    logic              pd_dly_q;
    logic              lpv_q, lpv_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [ADDR_W:0]   dest_ext;
    logic              dest_bad;
    logic              accepted;

    assign dest_ext = {1'b0, data_in[ADDR_W-1:0]};
    assign dest_bad = dest_ext >= (ADDR_W+1)'(NUM_PORTS);

    always_comb begin
        header_d     = header_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        hold_mem_d   = hold_mem_q;
        hold_cnt_d   = hold_cnt_q;
        hold_ovf_d   = hold_ovf_q;
        addr_err_d   = 1'b0;
        int_par_d    = int_par_q;
        ext_par_d    = ext_par_q;
        pd_d         = pd_q;
        lpv_d        = lpv_q;
        err_d        = err_q;
        err_cnt_d    = err_cnt_q;
        accepted     = 1'b0;

        // Error is judged in the cycle after parity_done rises, on the settled parity values.
        if (pd_q && !pd_dly_q && ((int_par_q != ext_par_q) || hold_ovf_q))
            err_d = 1'b1;
        if (rst_int_reg)
            lpv_d = 1'b0;

        if (detect_add) begin
            if (pkt_valid) begin
                if (dest_bad) addr_err_d = 1'b1;
                else          header_d   = data_in;
            end
            int_par_d  = '0;
            ext_par_d  = '0;
            pd_d       = 1'b0;
            err_d      = 1'b0;
            hold_cnt_d = '0;
            hold_ovf_d = 1'b0;
        end else if (lfd_state) begin
            dout_d       = header_q;
            dout_valid_d = 1'b1;
            int_par_d    = header_q;
        end else if (ld_state) begin
            if (!fifo_full && hold_cnt_q == '0) begin
                dout_d       = data_in;
                dout_valid_d = 1'b1;
                accepted     = 1'b1;
            end else if (hold_cnt_q == HOLD_FULL) begin
                hold_ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < HOLD_DEPTH; i++)
                    if (HC_W'(i) == hold_cnt_q) hold_mem_d[i] = data_in;
                hold_cnt_d = hold_cnt_q + 1'b1;
                accepted   = 1'b1;
            end
            if (accepted) begin
                if (pkt_valid) begin
                    int_par_d = parity_acc(int_par_q, data_in);
                end else begin
                    ext_par_d = data_in;
                    pd_d      = 1'b1;
                    lpv_d     = 1'b1;
                end
            end
        end else if (laf_state && hold_cnt_q != '0 && !fifo_full) begin
            dout_d       = hold_mem_q[0];
            dout_valid_d = 1'b1;
            for (int i = 0; i < HOLD_DEPTH - 1; i++)
                hold_mem_d[i] = hold_mem_q[i+1];
            hold_cnt_d = hold_cnt_q - 1'b1;
        end

        if (err_d && !err_q && err_cnt_q != {CNT_W{1'b1}})
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            header_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            hold_mem_q   <= '{default: '0};
            hold_cnt_q   <= '0;
            hold_ovf_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            int_par_q    <= '0;
            ext_par_q    <= '0;
            pd_q         <= 1'b0;
            pd_dly_q     <= 1'b0;
            lpv_q        <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            header_q     <= header_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            hold_mem_q   <= hold_mem_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_ovf_q   <= hold_ovf_d;
            addr_err_q   <= addr_err_d;
            int_par_q    <= int_par_d;
            ext_par_q    <= ext_par_d;
            pd_q         <= pd_d;
            pd_dly_q     <= pd_q;
            lpv_q        <= lpv_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign hold_cnt      = hold_cnt_q;
    assign hold_ovf      = hold_ovf_q;
    assign addr_err      = addr_err_q;
    assign low_pkt_valid = lpv_q;
    assign parity_done   = pd_q;
    assign err           = err_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: three parameterisations share one stimulus stream and are
// each compared every cycle against a packet-level reference model.
module tb_router_reg_param;
    localparam int S_IDLE = 0, S_DA = 1, S_LFD = 2, S_LD = 3, S_LAF = 4, S_FULL = 5;

    logic clk = 1'b0;
    logic resetn, pkt_valid, fifo_full, rst_int_reg;
    logic detect_add, lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1, dout2;
    logic       dv0, dv1, dv2, ovf0, ovf1, ovf2, ae0, ae1, ae2;
    logic       lpv0, lpv1, lpv2, pd0, pd1, pd2, er0, er1, er2;
    logic [1:0] hc0, hc2;
    logic       hc1;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_reg_param u0 (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout0), .dout_valid(dv0), .hold_cnt(hc0),
        .hold_ovf(ovf0), .addr_err(ae0), .low_pkt_valid(lpv0), .parity_done(pd0),
        .err(er0), .err_count(ec0));

    router_reg_param #(.HOLD_DEPTH(1)) u1 (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout1), .dout_valid(dv1), .hold_cnt(hc1),
        .hold_ovf(ovf1), .addr_err(ae1), .low_pkt_valid(lpv1), .parity_done(pd1),
        .err(er1), .err_count(ec1));

    router_reg_param #(.PARITY_MODE(1), .CNT_W(2)) u2 (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout2), .dout_valid(dv2), .hold_cnt(hc2),
        .hold_ovf(ovf2), .addr_err(ae2), .low_pkt_valid(lpv2), .parity_done(pd2),
        .err(er2), .err_count(ec2));

    // Reference model: per-instance packet state
    int         HD   [3] = '{2, 1, 2};
    int         PM   [3] = '{0, 0, 1};
    int         EMAX [3] = '{255, 255, 3};
    logic [7:0] m_hdr [3], m_dout [3], m_ip [3], m_ep [3];
    logic [7:0] m_buf [3][2];
    logic       m_dv [3], m_ovf [3], m_ae [3], m_lpv [3], m_pd [3], m_pdprev [3], m_err [3];
    int         m_cnt [3], m_ecnt [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] acc(input int k, input logic [7:0] a, input logic [7:0] b);
        if (PM[k] == 1) return 8'(a + b);
        return a ^ b;
    endfunction

    task automatic model_one(input int k);
        logic judge, old_err, took;
        if (!resetn) begin
            m_hdr[k] = 0; m_dout[k] = 0; m_ip[k] = 0; m_ep[k] = 0;
            m_buf[k][0] = 0; m_buf[k][1] = 0;
            m_dv[k] = 0; m_ovf[k] = 0; m_ae[k] = 0; m_lpv[k] = 0; m_pd[k] = 0;
            m_pdprev[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_ecnt[k] = 0;
            return;
        end
        judge   = m_pd[k] && !m_pdprev[k] && (m_ip[k] != m_ep[k] || m_ovf[k]);
        old_err = m_err[k];
        m_pdprev[k] = m_pd[k];
        m_dv[k] = 0;
        m_ae[k] = 0;
        if (judge) m_err[k] = 1;
        if (rst_int_reg) m_lpv[k] = 0;
        if (detect_add) begin
            if (pkt_valid) begin
                if (data_in[1:0] >= 2'd3) m_ae[k] = 1;
                else                      m_hdr[k] = data_in;
            end
            m_ip[k] = 0; m_ep[k] = 0; m_pd[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end else if (lfd_state) begin
            m_dout[k] = m_hdr[k]; m_dv[k] = 1; m_ip[k] = m_hdr[k];
        end else if (ld_state) begin
            took = 1;
            if (!fifo_full && m_cnt[k] == 0) begin
                m_dout[k] = data_in; m_dv[k] = 1;
            end else if (m_cnt[k] == HD[k]) begin
                took = 0; m_ovf[k] = 1;
            end else begin
                m_buf[k][m_cnt[k]] = data_in; m_cnt[k]++;
            end
            if (took && pkt_valid) m_ip[k] = acc(k, m_ip[k], data_in);
            if (took && !pkt_valid) begin
                m_ep[k] = data_in; m_pd[k] = 1; m_lpv[k] = 1;
            end
        end else if (laf_state && m_cnt[k] != 0 && !fifo_full) begin
            m_dout[k] = m_buf[k][0]; m_dv[k] = 1;
            m_buf[k][0] = m_buf[k][1];
            m_cnt[k]--;
        end
        if (m_err[k] && !old_err && m_ecnt[k] < EMAX[k]) m_ecnt[k]++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] a_dout, a_ec;
            logic [1:0] a_hc;
            logic a_dv, a_ovf, a_ae, a_lpv, a_pd, a_er;
            case (k)
                0: begin a_dout = dout0; a_dv = dv0; a_hc = hc0; a_ovf = ovf0; a_ae = ae0;
                         a_lpv = lpv0; a_pd = pd0; a_er = er0; a_ec = ec0; end
                1: begin a_dout = dout1; a_dv = dv1; a_hc = {1'b0, hc1}; a_ovf = ovf1; a_ae = ae1;
                         a_lpv = lpv1; a_pd = pd1; a_er = er1; a_ec = ec1; end
                default: begin a_dout = dout2; a_dv = dv2; a_hc = hc2; a_ovf = ovf2; a_ae = ae2;
                         a_lpv = lpv2; a_pd = pd2; a_er = er2; a_ec = {6'd0, ec2}; end
            endcase
            check($sformatf("u%0d.dout", k),          32'(a_dout), 32'(m_dout[k]));
            check($sformatf("u%0d.dout_valid", k),    32'(a_dv),   32'(m_dv[k]));
            check($sformatf("u%0d.hold_cnt", k),      32'(a_hc),   32'(m_cnt[k]));
            check($sformatf("u%0d.hold_ovf", k),      32'(a_ovf),  32'(m_ovf[k]));
            check($sformatf("u%0d.addr_err", k),      32'(a_ae),   32'(m_ae[k]));
            check($sformatf("u%0d.low_pkt_valid", k), 32'(a_lpv),  32'(m_lpv[k]));
            check($sformatf("u%0d.parity_done", k),   32'(a_pd),   32'(m_pd[k]));
            check($sformatf("u%0d.err", k),           32'(a_er),   32'(m_err[k]));
            check($sformatf("u%0d.err_count", k),     32'(a_ec),   32'(m_ecnt[k]));
        end
    endtask

    task automatic step(input int st, input logic pv, input logic [7:0] d, input logic ff);
        detect_add = (st == S_DA);
        lfd_state  = (st == S_LFD);
        ld_state   = (st == S_LD);
        laf_state  = (st == S_LAF);
        full_state = (st == S_FULL);
        pkt_valid  = pv;
        data_in    = d;
        fifo_full  = ff;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_one(k);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] hdr, b, par;
        resetn = 1'b0; rst_int_reg = 1'b0;
        step(S_IDLE, 0, 8'h00, 0);
        step(S_LD, 1, 8'h5A, 0);
        check("reset.dout", 32'(dout0), 32'h0);
        resetn = 1'b1;

        // Clean XOR packet, correct parity
        step(S_DA, 1, 8'h05, 0);
        step(S_LFD, 1, 8'h00, 0);  check("p1.hdr", 32'(dout0), 32'h05);
        step(S_LD, 1, 8'h11, 0);   check("p1.b1", 32'(dout0), 32'h11);
        step(S_LD, 1, 8'h22, 0);   check("p1.b2", 32'(dout0), 32'h22);
        step(S_LD, 0, 8'h36, 0);   check("p1.par", 32'(dout0), 32'h36);
        check("p1.pd", 32'(pd0), 32'h1);
        step(S_IDLE, 0, 8'h00, 0); check("p1.err", 32'(er0), 32'h0);

        // Same packet, bad parity
        step(S_DA, 1, 8'h05, 0);
        step(S_LFD, 1, 8'h00, 0);
        step(S_LD, 1, 8'h11, 0);
        step(S_LD, 1, 8'h22, 0);
        step(S_LD, 0, 8'h00, 0);   check("p2.err_early", 32'(er0), 32'h0);
        step(S_IDLE, 0, 8'h00, 0); check("p2.err", 32'(er0), 32'h1);
        check("p2.err_count", 32'(ec0), 32'h1);

        // Holding buffer: two bytes held, popped in order; depth-1 instance overflows
        step(S_DA, 1, 8'h05, 0);
        step(S_LFD, 1, 8'h00, 0);
        step(S_LD, 1, 8'hAA, 1);
        step(S_LD, 1, 8'hBB, 1);   check("p3.hold_cnt", 32'(hc0), 32'h2);
        check("p3.ovf_d1", 32'(ovf1), 32'h1);
        step(S_LAF, 0, 8'h00, 0);  check("p3.pop1", 32'(dout0), 32'hAA);
        step(S_LAF, 0, 8'h00, 0);  check("p3.pop2", 32'(dout0), 32'hBB);
        check("p3.ovf", 32'(ovf0), 32'h0);
        step(S_LD, 0, 8'h14, 0);
        step(S_IDLE, 0, 8'h00, 0); check("p3.err", 32'(er0), 32'h0);
        check("p3.err_d1", 32'(er1), 32'h1);

        // Bad destination, then modulo-sum parity
        step(S_DA, 1, 8'h03, 0);   check("p4.addr_err", 32'(ae0), 32'h1);
        step(S_LFD, 1, 8'h00, 0);  check("p4.hdr_kept", 32'(dout0), 32'h05);
        check("p4.addr_err_pulse", 32'(ae0), 32'h0);
        step(S_DA, 1, 8'h01, 0);
        step(S_LFD, 1, 8'h00, 0);
        step(S_LD, 1, 8'hFF, 0);
        step(S_LD, 1, 8'h02, 0);
        step(S_LD, 0, 8'h02, 0);
        step(S_IDLE, 0, 8'h00, 0); check("p4.sum_err", 32'(er2), 32'h0);
        check("p4.cnt_sat", 32'(ec2), 32'h3);

        // Reset mid-payload with a held byte
        step(S_DA, 1, 8'h05, 0);
        step(S_LFD, 1, 8'h00, 0);
        step(S_LD, 1, 8'h11, 1);   check("p5.hold", 32'(hc0), 32'h1);
        resetn = 1'b0;
        step(S_LD, 1, 8'h22, 0);
        check("p5.rst_hold", 32'(hc0), 32'h0);
        check("p5.rst_cnt", 32'(ec2), 32'h0);
        resetn = 1'b1;

        // Randomised packets
        for (int p = 0; p < 80; p++) begin
            hdr = 8'($urandom);
            if ($urandom_range(0, 5) == 0) hdr[1:0] = 2'd3;
            rst_int_reg = ($urandom_range(0, 5) == 0);
            step(S_DA, ($urandom_range(0, 9) != 0), hdr, 0);
            step(S_LFD, 1, 8'h00, 0);
            par = hdr;
            for (int i = 0, n = $urandom_range(1, 5); i < n; i++) begin
                rst_int_reg = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) step(S_FULL, 1, 8'($urandom), 1);
                if ($urandom_range(0, 4) == 0) step(S_LAF, 1, 8'($urandom), $urandom_range(0, 1) == 1);
                if ($urandom_range(0, 40) == 0) resetn = 1'b0;
                b = 8'($urandom);
                par = par ^ b;
                step(S_LD, 1, b, $urandom_range(0, 2) == 0);
                resetn = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) par = 8'($urandom);
            step(S_LD, 0, par, $urandom_range(0, 3) == 0);
            for (int i = 0, n = $urandom_range(1, 4); i < n; i++)
                step(S_LAF, 0, 8'($urandom), $urandom_range(0, 3) == 0);
            rst_int_reg = 1'b0;
            step(S_IDLE, 0, 8'($urandom), 0);
            step(S_IDLE, 0, 8'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
